// File: rtl/router_pkt_fifo_if.sv
// Handshake and status bundle between a router output channel and its packet FIFO.
// The master side writes and reads; the slave side is the FIFO itself.
interface router_pkt_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              pkt_done;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, full, empty, almost_full, count,
               pkt_done, overflow_err, underflow_err
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, full, empty, almost_full, count,
               pkt_done, overflow_err, underflow_err
    );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware output buffer for one router channel.
// Each entry holds a data word plus a header flag; reading a header loads a
// length counter so the read side gets a pkt_done pulse after the last word.
// Optional sticky error flags are built only when ROUTER_PKT_FIFO_ERR_EN is defined.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = 2,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    router_pkt_fifo_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int LEN_W = DATA_W - LEN_LSB;

    // Pointers carry one extra wrap bit above the index.
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic [6:0]        len_q, len_d;
    logic              pkt_done_q, pkt_done_d;

    logic              full_w;
    logic              empty_w;
    logic [PTR_W-1:0]  count_w;
    logic              do_wr;
    logic              do_rd;
    logic [DATA_W:0]   rd_entry;
    logic [LEN_W-1:0]  hdr_len;
    logic [6:0]        len_load;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign count_w = wr_ptr_q - rd_ptr_q;

    // Full/empty are sampled before the edge, so a write on full or a read
    // on empty is dropped even when the other side moves in the same cycle.
    assign do_wr = resetn && !soft_reset && bus.write_enb && !full_w;
    assign do_rd = resetn && !soft_reset && bus.read_enb  && !empty_w;

    assign rd_entry = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign hdr_len  = rd_entry[DATA_W-1:LEN_LSB];
    // Header length counts payload words; the extra one covers the parity word.
    assign len_load = 7'(hdr_len) + 7'd1;

    // Next-state for pointers, read data and packet length tracking.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        len_d        = len_q;
        pkt_done_d   = 1'b0;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            len_d      = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                data_out_d   = rd_entry[DATA_W-1:0];
                data_valid_d = 1'b1;
                if (rd_entry[DATA_W]) begin
                    // A header restarts tracking even if the previous packet was cut short.
                    len_d = len_load;
                end else if (len_q != 7'd0) begin
                    len_d      = len_q - 7'd1;
                    pkt_done_d = (len_q == 7'd1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            len_q        <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            len_q        <= len_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    // Entry storage: header flag in the top bit, data word below it.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
        if (do_wr) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.count       = count_w;
    assign bus.almost_full = (count_w >= PTR_W'(AF_LEVEL));

`ifdef ROUTER_PKT_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky misuse flags, cleared only by either reset.
    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write_enb && full_w) begin
                overflow_q <= 1'b1;
            end
            if (bus.read_enb && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;
`else
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: a default 8x16 instance and a 16x32 instance
// driven with the same request stream and checked every cycle against a
// queue-based reference model.
module tb_router_pkt_fifo;
    logic clock = 1'b0;
    logic resetn;
    logic soft_reset;

    always #5 clock = ~clock;

    router_pkt_fifo_if #(.DATA_W(8),  .DEPTH(16)) bus0 ();
    router_pkt_fifo_if #(.DATA_W(16), .DEPTH(32)) bus1 ();

    router_pkt_fifo #(.DATA_W(8), .DEPTH(16)) dut0 (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus0.slave)
    );

    router_pkt_fifo #(.DATA_W(16), .DEPTH(32)) dut1 (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus1.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, one slot per instance: entry = {header flag, 16-bit data}.
    logic [16:0] mq [2][$];
    int          m_dout  [2];
    bit          m_valid [2];
    bit          m_done  [2];
    bit          m_ovf   [2];
    bit          m_udf   [2];
    int          m_len   [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 32;
    endfunction

    task automatic model_step(input int k, input bit clr, input bit we, input bit re,
                              input bit lfd, input logic [15:0] data);
        logic [16:0] e;
        bit was_full;
        bit was_empty;
        if (clr) begin
            mq[k].delete();
            m_dout[k]  = 0;
            m_valid[k] = 0;
            m_done[k]  = 0;
            m_ovf[k]   = 0;
            m_udf[k]   = 0;
            m_len[k]   = 0;
        end else begin
            was_full  = (mq[k].size() == depth_of(k));
            was_empty = (mq[k].size() == 0);
`ifdef ROUTER_PKT_FIFO_ERR_EN
            if (we && was_full)  m_ovf[k] = 1;
            if (re && was_empty) m_udf[k] = 1;
`endif
            m_valid[k] = 0;
            m_done[k]  = 0;
            if (re && !was_empty) begin
                e = mq[k].pop_front();
                m_dout[k]  = int'(e[15:0]);
                m_valid[k] = 1;
                if (e[16]) begin
                    m_len[k] = (int'(e[15:0]) / 4 + 1) % 128;
                end else if (m_len[k] > 0) begin
                    if (m_len[k] == 1) m_done[k] = 1;
                    m_len[k] = m_len[k] - 1;
                end
            end
            if (we && !was_full) mq[k].push_back({lfd, data});
        end
    endtask

    task automatic compare_inst(input int k, input logic [31:0] cnt, input logic [31:0] f,
                                input logic [31:0] e, input logic [31:0] af, input logic [31:0] v,
                                input logic [31:0] d, input logic [31:0] pd, input logic [31:0] ov,
                                input logic [31:0] ud);
        int n;
        int dep;
        n   = mq[k].size();
        dep = depth_of(k);
        chk("count",         k, cnt, 32'(n));
        chk("full",          k, f,   32'(n == dep));
        chk("empty",         k, e,   32'(n == 0));
        chk("almost_full",   k, af,  32'(n >= dep - 2));
        chk("data_valid",    k, v,   32'(m_valid[k]));
        chk("data_out",      k, d,   32'(m_dout[k]));
        chk("pkt_done",      k, pd,  32'(m_done[k]));
        chk("overflow_err",  k, ov,  32'(m_ovf[k]));
        chk("underflow_err", k, ud,  32'(m_udf[k]));
    endtask

    // One clock: apply inputs after the falling edge, check just after the rising edge.
    task automatic step(input logic rn, input logic sr, input logic we, input logic re,
                        input logic lfd, input logic [7:0] din, input logic [7:0] hi);
        resetn          = rn;
        soft_reset      = sr;
        bus0.write_enb  = we;
        bus0.read_enb   = re;
        bus0.lfd_state  = lfd;
        bus0.data_in    = din;
        bus1.write_enb  = we;
        bus1.read_enb   = re;
        bus1.lfd_state  = lfd;
        bus1.data_in    = {hi, din};
        model_step(0, !rn || sr, we, re, lfd, {8'h00, din});
        model_step(1, !rn || sr, we, re, lfd, {hi, din});
        @(posedge clock);
        #1;
        compare_inst(0, 32'(bus0.count), 32'(bus0.full), 32'(bus0.empty), 32'(bus0.almost_full),
                     32'(bus0.data_valid), 32'(bus0.data_out), 32'(bus0.pkt_done),
                     32'(bus0.overflow_err), 32'(bus0.underflow_err));
        compare_inst(1, 32'(bus1.count), 32'(bus1.full), 32'(bus1.empty), 32'(bus1.almost_full),
                     32'(bus1.data_valid), 32'(bus1.data_out), 32'(bus1.pkt_done),
                     32'(bus1.overflow_err), 32'(bus1.underflow_err));
        @(negedge clock);
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, 1'b0, lfd, d, 8'h00);
    endtask

    task automatic rd();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic srst();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        // Hard reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00);
        idle();

        // One packet: header 0C (3 payload words), payload, parity; pkt_done after the parity read.
        wr(1'b1, 8'h0C);
        wr(1'b0, 8'hA1);
        wr(1'b0, 8'hA2);
        wr(1'b0, 8'hA3);
        wr(1'b0, 8'h5E);
        for (int i = 0; i < 5; i++) rd();
        idle();
        idle();

        // Fill past full and drain, twice, so both pointers wrap in both directions.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 17; i++) wr(1'b0, 8'(8'h40 + 16 * pass + i));
            for (int i = 0; i < 17; i++) rd();
        end

        // Simultaneous read and write while full, then while empty.
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
        for (int i = 0; i < 16; i++) rd();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
        rd();
        idle();

        // Soft reset in the middle of a packet, with requests pending; next packet tracked cleanly.
        wr(1'b1, 8'h0C);
        for (int i = 0; i < 4; i++) wr(1'b0, 8'(8'hC0 + i));
        rd();
        rd();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 8'h00);
        idle();
        wr(1'b1, 8'h04);
        wr(1'b0, 8'hB1);
        wr(1'b0, 8'hB2);
        for (int i = 0; i < 3; i++) rd();
        idle();

        // Error flags: read on empty, then write on full, held until soft reset.
        srst();
        rd();
        idle();
        for (int i = 0; i < 17; i++) wr(1'b0, 8'(8'h20 + i));
        idle();
        idle();
        srst();
        idle();

        // Fill the wide instance to 32 and one beyond, then drain.
        for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 8'(8'hE0 + i));
        for (int i = 0; i < 33; i++) rd();
        idle();

        // Wide header with high length bits set, then a random mixed workload in three bias phases.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h02);
        for (int i = 0; i < 3; i++) wr(1'b0, 8'(8'hD0 + i));
        for (int i = 0; i < 5; i++) rd();
        for (int i = 0; i < 600; i++) begin
            int wp;
            int rp;
            wp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
            rp = (i < 200) ? 30 : (i < 400) ? 70 : 50;
            step(1'b1,
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 4) == 0),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
